// File: rtl/i2cs_pkg.sv
// Shared constants and state encoding for the I2C-slave RAM read streamer.
package i2cs_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_e;

endpackage

// File: rtl/i2cs_ram_rd_stream.sv
// Streams a run of bytes out of the I2C-slave buffer RAM onto a valid/ready
// interface, one byte per cycle while the consumer keeps accepting.
module i2cs_ram_rd_stream
   import i2cs_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic [ADDR_W:0]   len_i,
   input  logic              abort_i,
   output logic [ADDR_W-1:0] ram_rd_addr_o,
   input  logic [DATA_W-1:0] ram_rd_data_i,
   output logic [DATA_W-1:0] tx_data_o,
   output logic              tx_valid_o,
   input  logic              tx_ready_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W:0]   rd_count_o
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   state_e              state_q;
   logic [ADDR_W-1:0]   ptr_q;
   logic [ADDR_W:0]     rem_q;
   logic [DATA_W-1:0]   tx_data_q;
   logic                tx_valid_q;
   logic                done_q;
   logic [ADDR_W:0]     rd_count_q;

   logic [ADDR_W:0]     len_sat;
   logic                handshake;

   always_comb begin
      len_sat   = (len_i > DEPTH) ? DEPTH : len_i;
      handshake = tx_valid_q && tx_ready_i;
   end

   // In IDLE the RAM is already addressed by start_addr_i so the first byte
   // can be captured on the same edge that accepts the start request.
   assign ram_rd_addr_o = (state_q == IDLE) ? start_addr_i : ptr_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         rem_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         done_q     <= 1'b0;
         rd_count_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i && !abort_i) begin
                  rd_count_q <= '0;
                  if (len_i == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q    <= STREAM;
                     tx_data_q  <= ram_rd_data_i;
                     tx_valid_q <= 1'b1;
                     ptr_q      <= start_addr_i + ADDR_W'(1);
                     rem_q      <= len_sat - (ADDR_W+1)'(1);
                  end
               end
            end
            STREAM: begin
               if (abort_i) begin
                  state_q    <= IDLE;
                  tx_valid_q <= 1'b0;
                  if (handshake) rd_count_q <= rd_count_q + (ADDR_W+1)'(1);
               end else if (handshake) begin
                  rd_count_q <= rd_count_q + (ADDR_W+1)'(1);
                  if (rem_q != '0) begin
                     tx_data_q <= ram_rd_data_i;
                     ptr_q     <= ptr_q + ADDR_W'(1);
                     rem_q     <= rem_q - (ADDR_W+1)'(1);
                  end else begin
                     tx_valid_q <= 1'b0;
                     state_q    <= DONE;
                     done_q     <= 1'b1;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_data_o  = tx_data_q;
   assign tx_valid_o = tx_valid_q;
   assign done_o     = done_q;
   assign rd_count_o = rd_count_q;
   assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_i2cs_ram_rd_stream.sv
// Directed bench for i2cs_ram_rd_stream with a 256x8 RAM model (RAM[i]=i)
// and a scoreboard queue of expected stream bytes.
module tb_i2cs_ram_rd_stream;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] start_addr = '0;
   logic [8:0] len = '0;
   logic       abort = 1'b0;
   logic [7:0] ram_rd_addr;
   logic [7:0] ram_rd_data;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic       busy;
   logic       done;
   logic [8:0] rd_count;

   logic [7:0] ram [256];
   logic [7:0] exp_q [$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc, first_valid_cyc, done_cyc;
   int hs_cnt, done_cnt, busy_cyc, valid_cyc;

   always #5 clk = ~clk;

   assign ram_rd_data = ram[ram_rd_addr];

   i2cs_ram_rd_stream dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .start_addr_i  (start_addr),
      .len_i         (len),
      .abort_i       (abort),
      .ram_rd_addr_o (ram_rd_addr),
      .ram_rd_data_i (ram_rd_data),
      .tx_data_o     (tx_data),
      .tx_valid_o    (tx_valid),
      .tx_ready_i    (tx_ready),
      .busy_o        (busy),
      .done_o        (done),
      .rd_count_o    (rd_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic clr_stats();
      hs_cnt = 0; done_cnt = 0; busy_cyc = 0; valid_cyc = 0;
      first_valid_cyc = -1; done_cyc = -1;
   endtask

   // One clock: sample/score at the falling edge, then let the rising edge pass.
   task automatic cycle();
      logic [7:0] e;
      cyc++;
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (tx_valid) begin
         valid_cyc++;
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
         if (tx_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
            else begin
               e = exp_q.pop_front();
               chk("stream_byte", {24'd0, tx_data}, {24'd0, e});
            end
         end else if (exp_q.size() != 0) begin
            chk("stall_hold", {24'd0, tx_data}, {24'd0, exp_q[0]});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic start_xfer(input logic [7:0] a, input logic [8:0] l);
      int n;
      n = (l > 9'd256) ? 256 : int'(l);
      for (int i = 0; i < n; i++) exp_q.push_back(8'(a + 8'(i)));
      start = 1'b1; start_addr = a; len = l;
      cycle();
      start_cyc = cyc;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin cycle(); n++; end
      if (n >= budget) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 8'(i);

      // Reset state
      start_addr = 8'h55;
      repeat (3) cycle();
      chk("rst_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_data", {24'd0, tx_data}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_count", {23'd0, rd_count}, 32'd0);
      chk("idle_addr_mux", {24'd0, ram_rd_addr}, 32'h55);
      rst_n = 1'b1;
      cycle();
      chk("post_rst_busy", {31'd0, busy}, 32'd0);

      // Basic 4-byte stream with continuous ready
      clr_stats(); tx_ready = 1'b1;
      start_xfer(8'h10, 9'd4);
      wait_idle(20);
      chk("basic_latency", 32'(first_valid_cyc - start_cyc), 32'd1);
      chk("basic_hs", 32'(hs_cnt), 32'd4);
      chk("basic_valid_cycles", 32'(valid_cyc), 32'd4);
      chk("basic_done_at", 32'(done_cyc - start_cyc), 32'd5);
      chk("basic_done_cnt", 32'(done_cnt), 32'd1);
      chk("basic_count", {23'd0, rd_count}, 32'd4);
      chk("basic_q_empty", 32'(exp_q.size()), 32'd0);

      // Address wrap
      clr_stats();
      start_xfer(8'hFE, 9'd4);
      wait_idle(20);
      chk("wrap_hs", 32'(hs_cnt), 32'd4);
      chk("wrap_count", {23'd0, rd_count}, 32'd4);
      chk("wrap_q_empty", 32'(exp_q.size()), 32'd0);

      // Back-pressure: ready 1,0,0,1,1
      clr_stats();
      start_xfer(8'h40, 9'd3);
      tx_ready = 1'b1; cycle();
      tx_ready = 1'b0; cycle();
      cycle();
      tx_ready = 1'b1; cycle();
      cycle();
      wait_idle(10);
      chk("stall_hs", 32'(hs_cnt), 32'd3);
      chk("stall_count", {23'd0, rd_count}, 32'd3);
      chk("stall_done_cnt", 32'(done_cnt), 32'd1);
      chk("stall_q_empty", 32'(exp_q.size()), 32'd0);

      // Empty transfer
      clr_stats();
      start_xfer(8'h20, 9'd0);
      wait_idle(10);
      chk("len0_valid_cycles", 32'(valid_cyc), 32'd0);
      chk("len0_done_at", 32'(done_cyc - start_cyc), 32'd1);
      chk("len0_busy_cycles", 32'(busy_cyc), 32'd1);
      chk("len0_count", {23'd0, rd_count}, 32'd0);

      // Abort after 3rd handshake; start while busy is ignored
      clr_stats(); tx_ready = 1'b1;
      start_xfer(8'h80, 9'd10);
      cycle();
      start = 1'b1; start_addr = 8'h00; len = 9'd5;
      cycle();
      start = 1'b0;
      cycle();
      tx_ready = 1'b0; abort = 1'b1;
      cycle();
      abort = 1'b0;
      chk("abort_valid", {31'd0, tx_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_count", {23'd0, rd_count}, 32'd3);
      cycle();
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      chk("abort_hs", 32'(hs_cnt), 32'd3);
      exp_q.delete();

      // start together with abort in IDLE stays idle
      clr_stats(); tx_ready = 1'b1;
      start = 1'b1; abort = 1'b1; start_addr = 8'h20; len = 9'd2;
      cycle();
      start = 1'b0; abort = 1'b0;
      chk("startabort_busy", {31'd0, busy}, 32'd0);
      cycle();
      chk("startabort_valid", 32'(valid_cyc), 32'd0);

      // Reset mid-transfer
      clr_stats();
      start_xfer(8'h30, 9'd8);
      cycle();
      cycle();
      tx_ready = 1'b0; rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      chk("midrst_valid", {31'd0, tx_valid}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_count", {23'd0, rd_count}, 32'd0);
      cycle();
      chk("midrst_no_done", 32'(done_cnt), 32'd0);
      exp_q.delete();

      // Saturating length: 300 -> 256 bytes
      clr_stats(); tx_ready = 1'b1;
      start_xfer(8'h00, 9'd300);
      wait_idle(400);
      chk("sat_hs", 32'(hs_cnt), 32'd256);
      chk("sat_count", {23'd0, rd_count}, 32'd256);
      chk("sat_done_cnt", 32'(done_cnt), 32'd1);
      chk("sat_q_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2cs_ram_rd_stream.md
I2CS_RAM_RD_STREAM -- requirements
Module: i2cs_ram_rd_stream

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: RAM address width, 256-entry buffer.
REQ-002 SHALL have parameter DATA_W, default 8: byte width.
REQ-003 SHALL have clk_i, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have rst_ni, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have start_i, input, 1: start request, sampled in IDLE only.
REQ-006 SHALL have start_addr_i, input, ADDR_W: first RAM address, sampled with start_i.
REQ-007 SHALL have len_i, input, ADDR_W+1: byte count; 0 = empty transfer; values >256 saturate to 256.
REQ-008 SHALL have abort_i, input, 1: cancel an active transfer.
REQ-009 SHALL have ram_rd_addr_o, output, ADDR_W: read address to the 256x8 buffer RAM.
REQ-010 SHALL have ram_rd_data_i, input, DATA_W: RAM read data, combinationally valid for the current ram_rd_addr_o.
REQ-011 SHALL have tx_data_o, output, DATA_W: streamed byte.
REQ-012 SHALL have tx_valid_o, output, 1: tx_data_o valid.
REQ-013 SHALL have tx_ready_i, input, 1: consumer accepts the byte when tx_valid_o && tx_ready_i.
REQ-014 SHALL have busy_o, output, 1: high in STREAM and DONE.
REQ-015 SHALL have done_o, output, 1: one-cycle pulse on normal completion.
REQ-016 SHALL have rd_count_o, output, ADDR_W+1: bytes accepted by the consumer in the current or last transfer.

Function
REQ-017 SHALL implement states IDLE, STREAM, DONE.
REQ-018 IDLE && start_i && !abort_i && len_i!=0 SHALL go to STREAM; at that edge: tx_data_o <= ram_rd_data_i with ram_rd_addr_o == start_addr_i, tx_valid_o <= 1, pointer <= start_addr_i+1, remaining <= sat(len_i)-1, rd_count_o <= 0.
REQ-019 In IDLE, ram_rd_addr_o SHALL equal start_addr_i (combinational mux); in STREAM/DONE it SHALL equal the internal pointer register.
REQ-020 IDLE && start_i && len_i==0 SHALL go to DONE with no tx_valid_o assertion, and rd_count_o <= 0.
REQ-021 Latency: first byte valid in the cycle after start_i is sampled.
REQ-022 On handshake in STREAM with remaining!=0: tx_data_o <= ram_rd_data_i, pointer++, remaining--, rd_count_o++, tx_valid_o stays 1 (one byte per cycle with continuous ready).
REQ-023 On handshake in STREAM with remaining==0: tx_valid_o <= 0, rd_count_o++, go to DONE.
REQ-024 While tx_valid_o && !tx_ready_i, tx_data_o, pointer, and remaining SHALL hold stable.
REQ-025 Pointer arithmetic SHALL be modulo 2^ADDR_W (255 wraps to 0); no error is flagged.
REQ-026 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-027 start_i in STREAM or DONE SHALL be ignored.
REQ-028 abort_i in STREAM SHALL force IDLE and tx_valid_o <= 0 at the next edge; done_o is not pulsed; rd_count_o keeps the count, including any handshake in the abort cycle.
REQ-029 abort_i together with start_i in IDLE SHALL be ignored (remain in IDLE); abort_i in DONE SHALL have no effect.
REQ-030 The block SHALL never write the RAM.

Reset
REQ-031 With rst_ni=0 at a rising edge: state=IDLE, tx_valid_o=0, tx_data_o=0, done_o=0, rd_count_o=0, pointer=0, remaining=0.
REQ-032 Reset mid-transfer SHALL take effect at the next edge, discarding the pending byte, with no done_o pulse.
REQ-033 busy_o SHALL be 0 during and immediately after reset.

Structure
REQ-034 Package i2cs_pkg SHALL hold the state enum (IDLE/STREAM/DONE) and the ADDR_W/DATA_W default constants.
REQ-035 SHALL be one flat module with no sub-module; the bench pairs it with the 256x8 buffer RAM model.

Verification
REQ-036 RAM[i]=i; start_addr=0x10, len=4, ready=1 -> bytes 0x10..0x13 on 4 consecutive cycles starting 1 cycle after start; done_o pulses the cycle after the last byte; rd_count_o=4.
REQ-037 start_addr=0xFE, len=4 -> bytes 0xFE,0xFF,0x00,0x01 (address wrap).
REQ-038 len=3, ready toggling 1,0,0,1,1 -> tx_data_o holds during stalls; 3 bytes accepted, no duplicates or drops.
REQ-039 len=0 -> no tx_valid_o; done_o pulses 1 cycle after start; busy_o high for exactly 1 cycle.
REQ-040 len=10, abort_i after the 3rd handshake -> tx_valid_o low next cycle, no done_o, rd_count_o=3; start_i while busy ignored; len=300 streams 256 bytes.
